// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver on the system clock: two-flop synchronizer,
// 3-sample majority vote per bit, optional parity, framing error and break handling.
module uart_rx_os16 #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       sys_clk,
   input  logic       sys_reset,
   input  logic       uart_rx,
   output logic [7:0] o_receive_data,
   output logic       o_receive_data_en,
   output logic       o_parity_err,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity8(input logic [7:0] d);
      return ^d;
   endfunction

   state_t          state_r;
   state_t          state_nx_s;
   logic            rx_meta_r;
   logic            rx_sync_r;
   logic            rx_prev_r;
   logic [1:0]      sync_vld_r;
   logic            armed_r;
   logic [TW-1:0]   tick_cnt_r;
   logic [3:0]      sub_r;
   logic [2:0]      bit_idx_r;
   logic            s7_r;
   logic            s8_r;
   logic [7:0]      shift_r;
   logic            par_bit_r;

   logic            tick_s;
   logic            vote_s;
   logic            vote_tick_s;
   logic            bit_end_s;
   logic            fall_s;
   logic            accept_s;
   logic            ferr_s;

   assign tick_s      = (tick_cnt_r == TICK_LAST);
   assign vote_s      = maj3(s7_r, s8_r, rx_sync_r);
   assign vote_tick_s = tick_s && (sub_r == 4'd9);
   assign bit_end_s   = tick_s && (sub_r == 4'd15);
   // A line found low after reset is only a start once it has been seen high first.
   assign fall_s      = armed_r && rx_prev_r && !rx_sync_r;

   // Synchronizer, edge history and post-reset arming of start detection.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         rx_meta_r  <= 1'b1;
         rx_sync_r  <= 1'b1;
         rx_prev_r  <= 1'b1;
         sync_vld_r <= 2'b00;
         armed_r    <= 1'b0;
      end else begin
         rx_meta_r  <= uart_rx;
         rx_sync_r  <= rx_meta_r;
         rx_prev_r  <= rx_sync_r;
         sync_vld_r <= {sync_vld_r[0], 1'b1};
         armed_r    <= armed_r | (sync_vld_r[1] & rx_sync_r);
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode and frame completion strobes.
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      ferr_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               state_nx_s = ST_START;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (vote_tick_s && vote_s) begin
               state_nx_s = ST_IDLE;
            end else if (bit_end_s) begin
               state_nx_s = ST_DATA;
            end else begin
               state_nx_s = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s && (bit_idx_r == 3'd7)) begin
               state_nx_s = PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
               state_nx_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (bit_end_s) begin
               state_nx_s = ST_STOP;
            end else begin
               state_nx_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            // Decided mid stop bit so a sender's next start edge is not missed.
            if (vote_tick_s) begin
               if (vote_s) begin
                  accept_s   = 1'b1;
                  state_nx_s = ST_IDLE;
               end else begin
                  ferr_s     = 1'b1;
                  state_nx_s = ST_BREAK;
               end
            end else begin
               state_nx_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            if (rx_sync_r) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_BREAK;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Oversample divider, sub-bit phase and data bit index; all held at zero in IDLE.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         tick_cnt_r <= '0;
         sub_r      <= 4'd0;
         bit_idx_r  <= 3'd0;
      end else if (state_r == ST_IDLE) begin
         tick_cnt_r <= '0;
         sub_r      <= 4'd0;
         bit_idx_r  <= 3'd0;
      end else begin
         if (tick_s) begin
            tick_cnt_r <= '0;
            sub_r      <= sub_r + 4'd1;
         end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
         end
         if ((state_r == ST_DATA) && bit_end_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
         end
      end
   end

   // Mid-bit samples, data shift register and received parity bit.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         s7_r      <= 1'b0;
         s8_r      <= 1'b0;
         shift_r   <= 8'h00;
         par_bit_r <= 1'b0;
      end else begin
         if (tick_s && (sub_r == 4'd7)) begin
            s7_r <= rx_sync_r;
         end
         if (tick_s && (sub_r == 4'd8)) begin
            s8_r <= rx_sync_r;
         end
         if (vote_tick_s && (state_r == ST_DATA)) begin
            shift_r <= {vote_s, shift_r[7:1]};
         end
         if (vote_tick_s && (state_r == ST_PARITY)) begin
            par_bit_r <= vote_s;
         end
      end
   end

   // Registered outputs: one-cycle strobes, held data and busy flag.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         o_receive_data    <= 8'h00;
         o_receive_data_en <= 1'b0;
         o_parity_err      <= 1'b0;
         o_frame_err       <= 1'b0;
         o_busy            <= 1'b0;
      end else begin
         o_receive_data_en <= accept_s;
         o_frame_err       <= ferr_s;
         o_busy            <= (state_nx_s != ST_IDLE);
         if (accept_s) begin
            o_receive_data <= shift_r;
            o_parity_err   <= PARITY_EN & (par_bit_r ^ parity8(shift_r) ^ PARITY_ODD);
         end else begin
            o_parity_err   <= 1'b0;
         end
      end
   end

endmodule
